weight_bank: RTL and testbench
==============================

# weight_bank

Loadable, parametrised kernel-weight store that replaces the fixed combinational opcode-to-weight lookup in the MobileNet datapath. Weights stream in one kernel row per beat over a valid/ready port after reset. The convolution controller then fetches a full ROWS x TAPS kernel by opcode with one-cycle registered latency. Kernels not yet loaded, and out-of-range opcodes, read as zero. This preserves the behaviour of the old default case.

## Interface
Parameters:
- WEIGHT_W, 10, bits per weight tap
- TAPS, 9, taps per kernel row
- ROWS, 3, rows per kernel
- DEPTH, 38, number of kernels stored
- ADDR_W, 6, opcode width; DEPTH <= 2**ADDR_W

Ports:
- i_clk  in  1  single clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_ld_valid  in  1  load beat valid
- o_ld_ready  out  1  bank accepts a load beat
- i_ld_data  in  TAPS*WEIGHT_W  one kernel row; tap 0 in the LSBs
- i_ld_clear  in  1  restart loading at kernel 0 and invalidate all kernels
- o_ld_done  out  1  all DEPTH kernels loaded
- i_rd_valid  in  1  fetch request
- i_rd_opcode  in  ADDR_W  kernel index to fetch
- o_rd_valid  out  1  o_weight valid, one-cycle pulse
- o_weight  out  ROWS*TAPS*WEIGHT_W  fetched kernel; row r at bits [(r+1)*TAPS*WEIGHT_W-1 : r*TAPS*WEIGHT_W]
- o_rd_err  out  1  present only with WGT_OOR_FLAG_EN

## Operation
- **Storage.** DEPTH x ROWS row registers plus one valid bit per kernel. Row contents are not reset. Valid bits are reset.
- **Load FSM** has three states: LOAD, FULL and CLEAR.
  - LOAD: o_ld_ready=1. A beat is accepted when i_ld_valid && o_ld_ready. It writes row `row_cnt` of kernel `k_cnt`.
    - row_cnt counts 0..ROWS-1 and wraps to 0.
    - On a wrap, valid[k_cnt] is set and k_cnt increments.
    - Accepting the last row of kernel DEPTH-1 moves the FSM to FULL.
  - FULL: o_ld_ready=0 and o_ld_done=1. Extra beats are ignored.
  - CLEAR: entered from any state when i_ld_clear=1.
    - All valid bits, k_cnt and row_cnt are zeroed; o_ld_ready=0.
    - The FSM moves to LOAD on the next cycle.
    - i_ld_clear has priority over a same-cycle load beat; that beat is dropped.
- **A partially loaded kernel stays invalid** until its last row is accepted.
- **Read path.**
  - When i_rd_valid=1, the bank registers o_weight and pulses o_rd_valid high on the next cycle.
  - o_weight returns the kernel contents if i_rd_opcode < DEPTH and valid[i_rd_opcode]=1; otherwise it returns all zeros.
  - o_weight holds its value between reads.
  - Reads are accepted in every state, with no backpressure, one per cycle.
- **Read/write collision.** A read in the same cycle as the write completing that kernel returns the pre-write state, which is zero because the kernel is still invalid. A read in the same cycle as i_ld_clear returns the pre-clear contents.

## Timing
- Reset values:
  - o_ld_ready=0, o_ld_done=0, o_rd_valid=0, o_weight=0, o_rd_err=0.
  - FSM=CLEAR, counters 0, valid bits 0.
- First cycle after reset deassertion: the FSM is in CLEAR, with o_ld_ready=0. o_ld_ready rises one cycle later.
- Load throughput: one row per cycle; ROWS*DEPTH beats to reach FULL. o_ld_done rises the cycle after the final beat.
- Read latency: exactly 1 cycle, request to o_rd_valid.
- Reset asserted mid-load: all outputs return to reset values asynchronously and loading restarts at kernel 0.

## Configuration
- WGT_OOR_FLAG_EN defined:
  - Adds port o_rd_err.
  - o_rd_err is asserted together with o_rd_valid when i_rd_opcode >= DEPTH or the kernel is invalid. In that case o_weight is still zero.
  - o_rd_err is low at all other times.
- WGT_OOR_FLAG_EN undefined:
  - No o_rd_err port.
  - Invalid or out-of-range reads silently return zero.

## Test plan
- **Reset, then read.** Reset, then read opcode 5 -> o_rd_valid=1 one cycle later with o_weight=0. With WGT_OOR_FLAG_EN, o_rd_err=1.
- **Full load.** Stream 114 beats; row data = {k[7:0], r[1:0]} replicated -> o_ld_done=1 the cycle after beat 114. Read opcode 37 -> rows 0/1/2 match the data written; o_rd_err=0.
- **Partial kernel.** Load 2 rows of kernel 0 and read opcode 0 -> zero. Load the 3rd row and read again -> data returned.
- **Out of range.** Read opcode 40 and opcode 63 after a full load -> zero; o_rd_err=1 when WGT_OOR_FLAG_EN is defined.
- **Clear with beat.** Assert i_ld_clear together with i_ld_valid after 10 kernels -> the beat is dropped, o_ld_ready=0 for 1 cycle, and reading opcode 3 returns zero. Reloading starts at kernel 0.
- **Back-to-back reads with mid-load reset.**
  - Back-to-back reads of opcodes 0,1,2 -> three consecutive o_rd_valid pulses with the matching data.
  - Assert i_rst_n low mid-stream -> outputs go to zero immediately.

Source files
------------

// File: rtl/weight_bank.sv
// weight_bank: loadable kernel-weight store for the MobileNet convolution datapath.
//
// Kernels are streamed in one row per beat over a valid/ready load port. The
// controller then fetches a whole ROWS x TAPS kernel by opcode with one cycle of
// registered latency. Kernels that are not yet loaded, and opcodes >= DEPTH, read
// as all zeros. This matches the default case of the old fixed lookup table.
//
// Optional feature macro: WGT_OOR_FLAG_EN
//   When defined, adds o_rd_err. It pulses with o_rd_valid for any read that
//   returns zero because the kernel is invalid or the opcode is out of range.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_ld_valid   load beat valid
//   o_ld_ready   bank accepts a load beat (LOAD state only)
//   i_ld_data    one kernel row, tap 0 in the LSBs
//   i_ld_clear   invalidate all kernels and restart loading at kernel 0
//   o_ld_done    all DEPTH kernels loaded (FULL state)
//   i_rd_valid   fetch request; accepted every cycle
//   i_rd_opcode  kernel index to fetch
//   o_rd_valid   one-cycle pulse, o_weight updated
//   o_weight     fetched kernel, row r at [(r+1)*TAPS*WEIGHT_W-1 : r*TAPS*WEIGHT_W]
//   o_rd_err     (WGT_OOR_FLAG_EN only) read returned zero for invalid/out-of-range

module weight_bank #(
    parameter int unsigned WEIGHT_W = 10,
    parameter int unsigned TAPS     = 9,
    parameter int unsigned ROWS     = 3,
    parameter int unsigned DEPTH    = 38,
    parameter int unsigned ADDR_W   = 6
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_ld_valid,
    output logic                           o_ld_ready,
    input  logic [TAPS*WEIGHT_W-1:0]       i_ld_data,
    input  logic                           i_ld_clear,
    output logic                           o_ld_done,
    input  logic                           i_rd_valid,
    input  logic [ADDR_W-1:0]              i_rd_opcode,
    output logic                           o_rd_valid,
    output logic [ROWS*TAPS*WEIGHT_W-1:0]  o_weight
`ifdef WGT_OOR_FLAG_EN
    ,
    output logic                           o_rd_err
`endif
);

    localparam int unsigned ROW_W = TAPS * WEIGHT_W;
    localparam int unsigned KER_W = ROWS * ROW_W;
    localparam int unsigned K_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned R_W   = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [K_W-1:0]    K_LAST    = K_W'(DEPTH - 1);
    localparam logic [R_W-1:0]    R_LAST    = R_W'(ROWS - 1);
    // One extra bit so DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        StLoad,
        StFull,
        StClear
    } ld_state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ld_state_e          state_q, state_d;
    logic [K_W-1:0]     k_cnt_q, k_cnt_d;
    logic [R_W-1:0]     row_cnt_q, row_cnt_d;
    logic [DEPTH-1:0]   kvalid_q, kvalid_d;

    // Row storage is deliberately not reset; the valid bits gate every read.
    logic [ROW_W-1:0]   mem_q [DEPTH][ROWS];

    logic               ld_accept;

    logic               rd_valid_q;
    logic [KER_W-1:0]   weight_q;
    logic               rd_in_range;
    logic [K_W-1:0]     rd_idx;
    logic               rd_hit;
    logic [KER_W-1:0]   rd_kernel;

    // ------------------------------------------------------------------
    // Load FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        k_cnt_d    = k_cnt_q;
        row_cnt_d  = row_cnt_q;
        kvalid_d   = kvalid_q;
        o_ld_ready = (state_q == StLoad);
        o_ld_done  = (state_q == StFull);
        // Clear wins over a same-cycle beat, so the beat is dropped here.
        ld_accept  = i_ld_valid && (state_q == StLoad) && !i_ld_clear;

        if (i_ld_clear) begin
            state_d   = StClear;
            k_cnt_d   = '0;
            row_cnt_d = '0;
            kvalid_d  = '0;
        end else begin
            unique case (state_q)
                StClear: begin
                    state_d   = StLoad;
                    k_cnt_d   = '0;
                    row_cnt_d = '0;
                    kvalid_d  = '0;
                end
                StLoad: begin
                    if (ld_accept) begin
                        if (row_cnt_q == R_LAST) begin
                            // Kernel becomes visible only once its last row lands.
                            row_cnt_d         = '0;
                            kvalid_d[k_cnt_q] = 1'b1;
                            if (k_cnt_q == K_LAST) begin
                                state_d = StFull;
                            end else begin
                                k_cnt_d = k_cnt_q + 1'b1;
                            end
                        end else begin
                            row_cnt_d = row_cnt_q + 1'b1;
                        end
                    end
                end
                StFull: begin
                    // Extra beats are ignored until a clear.
                end
                default: begin
                    state_d = StClear;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StClear;
            k_cnt_q   <= '0;
            row_cnt_q <= '0;
            kvalid_q  <= '0;
        end else begin
            state_q   <= state_d;
            k_cnt_q   <= k_cnt_d;
            row_cnt_q <= row_cnt_d;
            kvalid_q  <= kvalid_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (ld_accept) begin
            mem_q[k_cnt_q][row_cnt_q] <= i_ld_data;
        end
    end

    // ------------------------------------------------------------------
    // Read path. Uses the pre-edge valid bits, so a read colliding with the
    // completing write (or with a clear) sees the old state.
    // ------------------------------------------------------------------
    always_comb begin
        rd_in_range = ({1'b0, i_rd_opcode} < DEPTH_LIM);
        rd_idx      = rd_in_range ? i_rd_opcode[K_W-1:0] : '0;
        rd_hit      = rd_in_range && kvalid_q[rd_idx];
        rd_kernel   = '0;
        if (rd_hit) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                rd_kernel[r*ROW_W +: ROW_W] = mem_q[rd_idx][r];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_valid_q <= 1'b0;
            weight_q   <= '0;
        end else begin
            rd_valid_q <= i_rd_valid;
            if (i_rd_valid) begin
                weight_q <= rd_kernel;
            end
        end
    end

    assign o_rd_valid = rd_valid_q;
    assign o_weight   = weight_q;

`ifdef WGT_OOR_FLAG_EN
    logic rd_err_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_err_q <= 1'b0;
        end else begin
            rd_err_q <= i_rd_valid && !rd_hit;
        end
    end

    assign o_rd_err = rd_err_q;
`endif

endmodule

// File: tb/tb_weight_bank.sv
// Testbench for weight_bank: reference model + read scoreboard, a table of
// post-load read vectors, and hand-written sequences for partial kernels,
// clear-with-beat, read/write collision and asynchronous reset mid-load.

module tb_weight_bank;

    localparam int WW    = 10;
    localparam int TAPS  = 9;
    localparam int ROWS  = 3;
    localparam int DEPTH = 38;
    localparam int AW    = 6;
    localparam int RW    = TAPS * WW;
    localparam int KWD   = ROWS * RW;

    localparam int ST_LOAD  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_CLEAR = 2;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic             i_ld_valid;
    logic             o_ld_ready;
    logic [RW-1:0]    i_ld_data;
    logic             i_ld_clear;
    logic             o_ld_done;
    logic             i_rd_valid;
    logic [AW-1:0]    i_rd_opcode;
    logic             o_rd_valid;
    logic [KWD-1:0]   o_weight;
`ifdef WGT_OOR_FLAG_EN
    logic             o_rd_err;
`endif

    weight_bank #(
        .WEIGHT_W (WW),
        .TAPS     (TAPS),
        .ROWS     (ROWS),
        .DEPTH    (DEPTH),
        .ADDR_W   (AW)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_ld_valid  (i_ld_valid),
        .o_ld_ready  (o_ld_ready),
        .i_ld_data   (i_ld_data),
        .i_ld_clear  (i_ld_clear),
        .o_ld_done   (o_ld_done),
        .i_rd_valid  (i_rd_valid),
        .i_rd_opcode (i_rd_opcode),
        .o_rd_valid  (o_rd_valid),
        .o_weight    (o_weight)
`ifdef WGT_OOR_FLAG_EN
        ,
        .o_rd_err    (o_rd_err)
`endif
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model of the bank.
    logic [RW-1:0]  m_mem [DEPTH][ROWS];
    bit             m_valid [DEPTH];
    int             m_state;
    int             m_k;
    int             m_r;
    logic [KWD-1:0] last_w;

    typedef struct {
        logic [KWD-1:0] w;
        bit             err;
        int             due;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        int op;
        bit hit;
    } rd_vec_t;
    rd_vec_t tbl[9];

    task automatic chk(input string name, input bit ok, input logic [KWD-1:0] act,
                       input logic [KWD-1:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    function automatic logic [RW-1:0] pat(input int k, input int r, input logic [7:0] salt);
        logic [7:0]    kb;
        logic [1:0]    rb;
        logic [WW-1:0] t;
        kb = 8'(k) ^ salt;
        rb = 2'(r);
        t  = {kb, rb};
        return {TAPS{t}};
    endfunction

    function automatic logic [KWD-1:0] kern_pat(input int k, input logic [7:0] salt);
        logic [KWD-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r*RW +: RW] = pat(k, r, salt);
        return v;
    endfunction

    function automatic logic [KWD-1:0] m_kernel(input int op);
        logic [KWD-1:0] v;
        v = '0;
        if (op < DEPTH && m_valid[op]) begin
            for (int r = 0; r < ROWS; r++) v[r*RW +: RW] = m_mem[op][r];
        end
        return v;
    endfunction

    task automatic model_reset();
        m_state = ST_CLEAR;
        m_k     = 0;
        m_r     = 0;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        sb.delete();
        last_w  = '0;
    endtask

    // One clock cycle of stimulus; the model advances at the clock edge.
    task automatic drive(input bit ld_v, input logic [RW-1:0] ld_d, input bit clr,
                         input bit rd_v, input int op, input bit use_exp,
                         input logic [KWD-1:0] exp_w, input bit exp_err);
        sb_t e;
        bit  acc;
        i_ld_valid  = ld_v;
        i_ld_data   = ld_d;
        i_ld_clear  = clr;
        i_rd_valid  = rd_v;
        i_rd_opcode = AW'(op);
        if (rd_v && i_rst_n) begin
            e.due = cyc + 1;
            if (use_exp) begin
                e.w   = exp_w;
                e.err = exp_err;
            end else begin
                e.w   = m_kernel(op);
                e.err = !(op < DEPTH && m_valid[op]);
            end
            sb.push_back(e);
        end
        acc = ld_v && !clr && (m_state == ST_LOAD);
        @(posedge i_clk);
        if (i_rst_n) begin
            if (clr) begin
                m_state = ST_CLEAR;
                m_k     = 0;
                m_r     = 0;
                for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
            end else begin
                case (m_state)
                    ST_CLEAR: m_state = ST_LOAD;
                    ST_LOAD: begin
                        if (acc) begin
                            m_mem[m_k][m_r] = ld_d;
                            if (m_r == ROWS - 1) begin
                                m_r          = 0;
                                m_valid[m_k] = 1'b1;
                                if (m_k == DEPTH - 1) m_state = ST_FULL;
                                else m_k++;
                            end else begin
                                m_r++;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
        #1;
        i_ld_valid = 1'b0;
        i_ld_clear = 1'b0;
        i_rd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, 0, 0, 0, 0, '0, 0);
    endtask

    task automatic beat(input int k, input int r, input logic [7:0] salt);
        drive(1, pat(k, r, salt), 0, 0, 0, 0, '0, 0);
    endtask

    task automatic load_kernels(input int first, input int n, input logic [7:0] salt);
        for (int k = first; k < first + n; k++)
            for (int r = 0; r < ROWS; r++) beat(k, r, salt);
    endtask

    task automatic rd(input int op);
        drive(0, '0, 0, 1, op, 0, '0, 0);
    endtask

    task automatic reset_now();
        i_rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_rd_valid", o_rd_valid == 1'b0, KWD'(o_rd_valid), '0);
        chk("rst_weight", o_weight == '0, o_weight, '0);
        chk("rst_ld_ready", o_ld_ready == 1'b0, KWD'(o_ld_ready), '0);
        chk("rst_ld_done", o_ld_done == 1'b0, KWD'(o_ld_done), '0);
`ifdef WGT_OOR_FLAG_EN
        chk("rst_rd_err", o_rd_err == 1'b0, KWD'(o_rd_err), '0);
`endif
    endtask

    // Monitor: every cycle, compare outputs against the model and scoreboard.
    always @(negedge i_clk) begin
        bit exp_rv;
        bit exp_err;
        exp_rv  = (sb.size() > 0) && (sb[0].due == cyc);
        exp_err = 1'b0;
        if (exp_rv) begin
            last_w  = sb[0].w;
            exp_err = sb[0].err;
            sb.delete(0);
        end
        chk("rd_valid", o_rd_valid === exp_rv, KWD'(o_rd_valid), KWD'(exp_rv));
        chk("weight", o_weight === last_w, o_weight, last_w);
`ifdef WGT_OOR_FLAG_EN
        chk("rd_err", o_rd_err === exp_err, KWD'(o_rd_err), KWD'(exp_err));
`endif
        chk("ld_ready", o_ld_ready === (m_state == ST_LOAD), KWD'(o_ld_ready),
            KWD'(m_state == ST_LOAD));
        chk("ld_done", o_ld_done === (m_state == ST_FULL), KWD'(o_ld_done),
            KWD'(m_state == ST_FULL));
    end

    initial begin
        tbl[0] = '{op: 37, hit: 1'b1};
        tbl[1] = '{op: 0,  hit: 1'b1};
        tbl[2] = '{op: 1,  hit: 1'b1};
        tbl[3] = '{op: 2,  hit: 1'b1};
        tbl[4] = '{op: 40, hit: 1'b0};
        tbl[5] = '{op: 63, hit: 1'b0};
        tbl[6] = '{op: 38, hit: 1'b0};
        tbl[7] = '{op: 36, hit: 1'b1};
        tbl[8] = '{op: 5,  hit: 1'b1};

        i_rst_n     = 1'b0;
        i_ld_valid  = 1'b0;
        i_ld_data   = '0;
        i_ld_clear  = 1'b0;
        i_rd_valid  = 1'b0;
        i_rd_opcode = '0;
        model_reset();

        // Reset, release; FSM spends one cycle in CLEAR before LOAD.
        idle(3);
        i_rst_n = 1'b1;
        idle(1);

        // Read before anything is loaded.
        rd(5);

        // Partial kernel 0, then a read colliding with the completing row.
        beat(0, 0, 8'h00);
        beat(0, 1, 8'h00);
        rd(0);
        drive(1, pat(0, 2, 8'h00), 0, 1, 0, 1, '0, 1);
        drive(0, '0, 0, 1, 0, 1, kern_pat(0, 8'h00), 0);

        // Remaining kernels up to FULL, then a beat that must be ignored.
        load_kernels(1, DEPTH - 1, 8'h00);
        drive(1, {RW{1'b1}}, 0, 0, 0, 0, '0, 0);

        // Back-to-back table reads after the full load.
        for (int i = 0; i < 9; i++) begin
            drive(0, '0, 0, 1, tbl[i].op, 1,
                  tbl[i].hit ? kern_pat(tbl[i].op, 8'h00) : '0, !tbl[i].hit);
        end
        idle(1);

        // Clear, reload 10 kernels, then clear together with a beat and a read.
        drive(0, '0, 1, 0, 0, 0, '0, 0);
        idle(1);
        load_kernels(0, 10, 8'h33);
        drive(1, pat(10, 0, 8'h33), 1, 1, 3, 1, kern_pat(3, 8'h33), 0);
        drive(0, '0, 0, 1, 3, 1, '0, 1);
        load_kernels(0, 1, 8'h77);
        drive(0, '0, 0, 1, 0, 1, kern_pat(0, 8'h77), 0);
        drive(0, '0, 0, 1, 1, 1, '0, 1);

        // Mid-load asynchronous reset while a read result is being presented.
        beat(1, 0, 8'h77);
        drive(1, pat(1, 1, 8'h77), 0, 1, 0, 0, '0, 0);
        chk("pre_rst_weight", o_weight == kern_pat(0, 8'h77), o_weight, kern_pat(0, 8'h77));
        reset_now();
        idle(2);
        i_rst_n = 1'b1;
        idle(1);
        load_kernels(0, 1, 8'hC3);
        drive(0, '0, 0, 1, 0, 1, kern_pat(0, 8'hC3), 0);
        drive(0, '0, 0, 1, 1, 1, '0, 1);
        idle(2);

        chk("sb_drained", sb.size() == 0, KWD'(sb.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
